aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter CYCLES_PER_ROUND, default 2: cycles per AES round, which allows key_scheduler settling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock, the 10 MHz domain; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: a plaintext/key pair is offered.
REQ-005 SHALL have port in_ready, output, 1: the block accepts a new pair.
REQ-006 SHALL have port in_block, input, 128 [0:127]: plaintext; byte 0 is bits 0..7.
REQ-007 SHALL have port in_key, input, 128 [0:127]: cipher key.
REQ-008 SHALL have port out_valid, output, 1: ciphertext available.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the ciphertext.
REQ-010 SHALL have port out_block, output, 128 [0:127]: ciphertext, equal to the state register.
REQ-011 SHALL have port dp_state, output, 128 [0:127]: state register, driven to the sbox/shift_rows/mix_col datapath.
REQ-012 SHALL have port dp_shift, input, 128 [0:127]: shift_rows(sub_bytes(dp_state)).
REQ-013 SHALL have port dp_mix, input, 128 [0:127]: mix_col(dp_shift).
REQ-014 SHALL have port dp_key, output, 128 [0:127]: current round key, driven to key_scheduler key_in.
REQ-015 SHALL have port dp_next_key, input, 128 [0:127]: key_scheduler output for dp_round.
REQ-016 SHALL have port dp_round, output, 5 [0:4]: round number, driven to key_scheduler round_in.
REQ-017 SHALL have port busy, output, 1: high in LOAD or ROUND.

Function
REQ-018 SHALL implement the FSM states IDLE, ROUND and DONE; LOAD is not a separate state, and the load happens on the accept edge.
REQ-019 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in ROUND.
REQ-020 On an accept edge (IDLE, in_valid=1), the block SHALL:
- load state <= in_block ^ in_key
- load key <= in_key
- set dp_round <= 1 and cnt <= 0
- go to ROUND.
REQ-021 In ROUND, cnt SHALL increment each cycle while cnt < CYCLES_PER_ROUND-1; no state/key update occurs before the commit cycle.
REQ-022 On the commit cycle (cnt = CYCLES_PER_ROUND-1), the block SHALL:
- load key <= dp_next_key
- reset cnt <= 0
- for dp_round 1..9: load state <= dp_mix ^ dp_next_key, then dp_round <= dp_round+1
- for dp_round 10: load state <= dp_shift ^ dp_next_key, leave dp_round at 10, go to DONE.
REQ-023 dp_round SHALL never exceed 10 and SHALL never wrap.
REQ-024 Latency from the accept edge to the first out_valid=1 cycle SHALL be exactly 10*CYCLES_PER_ROUND cycles.
REQ-025 In DONE, out_block and out_valid SHALL hold stable until out_ready=1; on that edge the FSM goes to IDLE and dp_round <= 0.
REQ-026 in_valid while not IDLE SHALL be ignored; the in_block/in_key changes SHALL have no effect.
REQ-027 out_ready while not DONE SHALL be ignored.
REQ-028 If in_valid=1 and out_ready=1 in the same DONE cycle, the output handshake SHALL complete; the input SHALL NOT be accepted until the following IDLE cycle.
REQ-029 Back-to-back operation SHALL be supported: minimum spacing between accepts is 10*CYCLES_PER_ROUND+2 cycles.
REQ-030 All outputs SHALL be registered or decoded from the FSM only, with no combinational path from inputs to outputs.

Reset
REQ-031 While reset=1, outputs SHALL be:
- FSM=IDLE
- state=0, key=0, cnt=0, dp_round=0
- in_ready=1, out_valid=0, busy=0
- out_block=0, dp_state=0, dp_key=0.
REQ-032 Reset asserted mid-ROUND or in DONE SHALL abort the operation immediately (asynchronously); no partial result is ever presented after reset.
REQ-033 After reset deassertion, the first edge with in_valid=1 SHALL be accepted.

Verification
REQ-034 The bench SHALL cover FIPS-197 with CYCLES_PER_ROUND=2, the real key_scheduler/sbox/shift_rows/mix_col, and out_ready=1:
- stimulus: in_block 3243f6a8885a308d313198a2e0370734, in_key 2b7e151628aed2a6abf7158809cf4f3c
- response: out_block 3925841d02dc09fbdc118597196a0b32, with out_valid rising exactly 20 cycles after accept.
REQ-035 The bench SHALL cover backpressure: same vector, out_ready held 0 for 50 cycles -> out_valid stays 1, out_block is stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-036 The bench SHALL cover ignored input: in_valid pulsed with a different block during ROUND -> result is still 3925841d...0b32 and the accept count is 1.
REQ-037 The bench SHALL cover reset at the round-5 commit cycle:
- reset -> all outputs match REQ-031
- the vector is then re-sent -> correct ciphertext after 20 cycles.
REQ-038 The bench SHALL cover CYCLES_PER_ROUND=1 and 3 with a behavioral key_scheduler model settling within 1 cycle -> correct ciphertext at latencies 10 and 30.
REQ-039 The bench SHALL cover simultaneous events: in_valid=1 and out_ready=1 in DONE -> output consumed, new pair accepted on the next edge, second ciphertext correct.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencing controller for an iterative AES-128 encryptor.
// Holds the 128-bit state and round-key registers, drives the external
// sbox/shift_rows/mix_col datapath and key scheduler, and spends
// CYCLES_PER_ROUND clock cycles on each of the ten rounds so the external
// logic has time to settle.
//
// Handshake (both ports): a transfer happens on a rising edge where valid
// and ready are both 1. in_ready is 1 only in IDLE, so an accepted pair is
// loaded on that edge. out_valid is 1 only in DONE; out_block is held until
// out_ready=1 is seen on an edge. in_ready and out_valid are decoded from
// the FSM register only, so neither depends combinationally on the other
// side's valid/ready. A DONE cycle that sees both out_ready and in_valid
// completes only the output transfer; the new pair is taken in the IDLE
// cycle that follows.
module aes_round_ctrl #(
    parameter int CYCLES_PER_ROUND = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_block,
    input  logic [0:127] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_block,
    output logic [0:127] dp_state,
    input  logic [0:127] dp_shift,
    input  logic [0:127] dp_mix,
    output logic [0:127] dp_key,
    input  logic [0:127] dp_next_key,
    output logic [0:4]   dp_round,
    output logic         busy,
    output logic [1:0]   fsm_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Last cnt value of a round: the edge that commits the round result.
    localparam logic [3:0] CNT_LAST   = 4'(CYCLES_PER_ROUND - 1);
    localparam logic [0:4] LAST_ROUND = 5'd10;

    logic [1:0]   fsm_q;
    logic [0:127] state_q;
    logic [0:127] key_q;
    logic [3:0]   cnt_q;
    logic [0:4]   round_q;

    // FSM, state/key registers, settling counter and round number.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        // Initial AddRoundKey happens as the pair is loaded.
                        state_q <= in_block ^ in_key;
                        key_q   <= in_key;
                        round_q <= 5'd1;
                        cnt_q   <= '0;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    if (cnt_q == CNT_LAST) begin
                        key_q <= dp_next_key;
                        cnt_q <= '0;
                        if (round_q == LAST_ROUND) begin
                            // Final round has no MixColumns.
                            state_q <= dp_shift ^ dp_next_key;
                            fsm_q   <= DONE;
                        end else begin
                            state_q <= dp_mix ^ dp_next_key;
                            round_q <= round_q + 5'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q   <= IDLE;
                        round_q <= '0;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers or from a decode of the FSM.
    always_comb begin
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
        busy      = (fsm_q == ROUND);
        out_block = state_q;
        dp_state  = state_q;
        dp_key    = key_q;
        dp_round  = round_q;
        fsm_state = fsm_q;
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: three controllers (CYCLES_PER_ROUND = 1, 2, 3), each
// wired to a behavioural AES-128 datapath and key scheduler. Table-driven
// known-answer vectors, then directed multi-cycle sequences on the
// CYCLES_PER_ROUND=2 instance.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

    typedef logic [0:127] blk_t;

    typedef struct {
        blk_t pt;
        blk_t key;
        blk_t ct;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals, index k -> CYCLES_PER_ROUND k+1 -------
    logic       in_valid_a  [3];
    logic       in_ready_a  [3];
    logic       out_valid_a [3];
    logic       out_ready_a [3];
    logic       busy_a      [3];
    blk_t       in_block_a  [3];
    blk_t       in_key_a    [3];
    blk_t       out_block_a [3];
    blk_t       dp_state_a  [3];
    blk_t       dp_shift_a  [3];
    blk_t       dp_mix_a    [3];
    blk_t       dp_key_a    [3];
    blk_t       dp_next_a   [3];
    logic [0:4] dp_round_a  [3];
    logic [1:0] fsm_a       [3];

    // ---------------- behavioural AES datapath ----------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] base;
        int e;
        r = 8'h01;
        base = x;
        e = 254;
        while (e != 0) begin
            if ((e & 1) != 0) r = gmul(r, base);
            base = gmul(base, base);
            e = e >> 1;
        end
        if (x == 8'h00) r = 8'h00;
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic blk_t sub_shift(input blk_t b);
        blk_t o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(r+4*c) +: 8] = sbox(b[8*(r+4*((c+r)%4)) +: 8]);
        return o;
    endfunction

    function automatic blk_t mix_columns(input blk_t b);
        blk_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = b[32*c +: 8];
            a1 = b[32*c+8 +: 8];
            a2 = b[32*c+16 +: 8];
            a3 = b[32*c+24 +: 8];
            o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic blk_t next_key(input blk_t k, input logic [0:4] rnd);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < int'(rnd); i++) rc = xtime(rc);
        w0 = k[0 +: 32];
        w1 = k[32 +: 32];
        w2 = k[64 +: 32];
        w3 = k[96 +: 32];
        t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t[31:24] = t[31:24] ^ rc;
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_ctrl #(.CYCLES_PER_ROUND(g + 1)) dut (
            .clk         (clk),
            .reset       (reset),
            .in_valid    (in_valid_a[g]),
            .in_ready    (in_ready_a[g]),
            .in_block    (in_block_a[g]),
            .in_key      (in_key_a[g]),
            .out_valid   (out_valid_a[g]),
            .out_ready   (out_ready_a[g]),
            .out_block   (out_block_a[g]),
            .dp_state    (dp_state_a[g]),
            .dp_shift    (dp_shift_a[g]),
            .dp_mix      (dp_mix_a[g]),
            .dp_key      (dp_key_a[g]),
            .dp_next_key (dp_next_a[g]),
            .dp_round    (dp_round_a[g]),
            .busy        (busy_a[g]),
            .fsm_state   (fsm_a[g])
        );
        assign dp_shift_a[g] = sub_shift(dp_state_a[g]);
        assign dp_mix_a[g]   = mix_columns(dp_shift_a[g]);
        assign dp_next_a[g]  = next_key(dp_key_a[g], dp_round_a[g]);
    end

    // ---------------- accept counter ----------------
    int acc_cnt [3];
    initial for (int i = 0; i < 3; i++) acc_cnt[i] = 0;
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (!reset && in_valid_a[i] && in_ready_a[i]) acc_cnt[i] <= acc_cnt[i] + 1;
    end

    // ---------------- scoreboard counters and checks ----------------
    int tests = 0;
    int fails = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input blk_t act, input blk_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input blk_t pt, input blk_t key);
        in_block_a[k] = pt;
        in_key_a[k]   = key;
        in_valid_a[k] = 1'b1;
        step();
        in_valid_a[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, output int n);
        n = 0;
        while (!out_valid_a[k] && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        check_bit({tag, " in_ready"}, in_ready_a[k], 1'b1);
        check_bit({tag, " out_valid"}, out_valid_a[k], 1'b0);
        check_bit({tag, " busy"}, busy_a[k], 1'b0);
        check_blk({tag, " out_block"}, out_block_a[k], '0);
        check_blk({tag, " dp_state"}, dp_state_a[k], '0);
        check_blk({tag, " dp_key"}, dp_key_a[k], '0);
        check_int({tag, " dp_round"}, int'(dp_round_a[k]), 0);
        check_int({tag, " fsm"}, int'(fsm_a[k]), 0);
    endtask

    // One full transaction with out_ready held high from the accept on.
    task automatic run_txn(input int k, input blk_t pt, input blk_t key, input blk_t ct,
                           input string tag);
        int n;
        check_bit({tag, " in_ready before"}, in_ready_a[k], 1'b1);
        out_ready_a[k] = 1'b1;
        send(k, pt, key);
        check_bit({tag, " busy after accept"}, busy_a[k], 1'b1);
        wait_out(k, n);
        check_int({tag, " latency"}, n, 10 * (k + 1));
        check_blk({tag, " ciphertext"}, out_block_a[k], ct);
        step();
        out_ready_a[k] = 1'b0;
        check_bit({tag, " idle after handshake"}, in_ready_a[k], 1'b1);
        check_bit({tag, " out_valid dropped"}, out_valid_a[k], 1'b0);
    endtask

    // ---------------- test ----------------
    vec_t vecs [3];

    initial begin
        int n;
        int a0;
        int bad_v;
        int bad_b;
        int bad_r;

        vecs[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734,
                    key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff,
                    key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{pt: 128'h0, key: 128'h0,
                    ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b0;
            in_block_a[k]  = '0;
            in_key_a[k]    = '0;
        end

        // Reset values, sampled before any clock edge.
        reset = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) check_reset_vals(k, $sformatf("reset c%0d", k + 1));
        step();
        step();
        reset = 1'b0;

        // Known-answer vectors on every CYCLES_PER_ROUND variant.
        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 3; v++)
                run_txn(k, vecs[v].pt, vecs[v].key, vecs[v].ct,
                        $sformatf("kat c%0d v%0d", k + 1, v));

        // Backpressure: out_ready low for 50 cycles in DONE, in_valid pulled meanwhile.
        a0 = acc_cnt[1];
        out_ready_a[1] = 1'b0;
        send(1, vecs[0].pt, vecs[0].key);
        wait_out(1, n);
        check_int("bp latency", n, 20);
        check_blk("bp ciphertext", out_block_a[1], vecs[0].ct);
        bad_v = 0;
        bad_b = 0;
        bad_r = 0;
        in_block_a[1] = vecs[1].pt;
        in_key_a[1]   = vecs[1].key;
        in_valid_a[1] = 1'b1;
        repeat (50) begin
            step();
            if (out_valid_a[1] !== 1'b1) bad_v++;
            if (out_block_a[1] !== vecs[0].ct) bad_b++;
            if (in_ready_a[1] !== 1'b0) bad_r++;
        end
        in_valid_a[1] = 1'b0;
        check_int("bp out_valid drops", bad_v, 0);
        check_int("bp out_block changes", bad_b, 0);
        check_int("bp in_ready highs", bad_r, 0);
        out_ready_a[1] = 1'b1;
        step();
        out_ready_a[1] = 1'b0;
        check_bit("bp idle after release", in_ready_a[1], 1'b1);
        check_bit("bp out_valid after release", out_valid_a[1], 1'b0);
        check_int("bp dp_round after release", int'(dp_round_a[1]), 0);
        check_int("bp accept count", acc_cnt[1] - a0, 1);

        // Input offered during ROUND must be ignored.
        a0 = acc_cnt[1];
        out_ready_a[1] = 1'b1;
        send(1, vecs[0].pt, vecs[0].key);
        repeat (3) step();
        in_block_a[1] = vecs[1].pt;
        in_key_a[1]   = vecs[1].key;
        in_valid_a[1] = 1'b1;
        repeat (4) step();
        in_valid_a[1] = 1'b0;
        wait_out(1, n);
        check_int("ign latency", n + 7, 20);
        check_blk("ign ciphertext", out_block_a[1], vecs[0].ct);
        step();
        out_ready_a[1] = 1'b0;
        check_int("ign accept count", acc_cnt[1] - a0, 1);

        // Asynchronous reset during the round-5 commit cycle.
        send(1, vecs[0].pt, vecs[0].key);
        repeat (9) step();
        check_int("mid round number", int'(dp_round_a[1]), 5);
        check_bit("mid busy", busy_a[1], 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals(1, "async reset");
        step();
        step();
        check_bit("held reset out_valid", out_valid_a[1], 1'b0);
        reset = 1'b0;
        run_txn(1, vecs[0].pt, vecs[0].key, vecs[0].ct, "after reset");

        // Simultaneous out_ready and in_valid in DONE.
        a0 = acc_cnt[1];
        out_ready_a[1] = 1'b0;
        send(1, vecs[0].pt, vecs[0].key);
        wait_out(1, n);
        check_int("sim first latency", n, 20);
        check_blk("sim first ciphertext", out_block_a[1], vecs[0].ct);
        in_block_a[1]  = vecs[1].pt;
        in_key_a[1]    = vecs[1].key;
        in_valid_a[1]  = 1'b1;
        out_ready_a[1] = 1'b1;
        step();
        check_bit("sim idle after handshake", in_ready_a[1], 1'b1);
        check_bit("sim not busy after handshake", busy_a[1], 1'b0);
        check_bit("sim out_valid after handshake", out_valid_a[1], 1'b0);
        step();
        in_valid_a[1]  = 1'b0;
        out_ready_a[1] = 1'b0;
        check_bit("sim busy after second accept", busy_a[1], 1'b1);
        wait_out(1, n);
        check_int("sim second latency", n, 20);
        check_blk("sim second ciphertext", out_block_a[1], vecs[1].ct);
        out_ready_a[1] = 1'b1;
        step();
        out_ready_a[1] = 1'b0;
        check_int("sim accept count", acc_cnt[1] - a0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
